// File: rtl/sd_init_ctrl_pkg.sv
// Shared constants and types for the SD card initialisation sequencer.
package sd_init_ctrl_pkg;

    // Command indices
    localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
    localparam logic [5:0] CMD_ALL_SEND_CID = 6'd2;
    localparam logic [5:0] CMD_SEND_RCA     = 6'd3;
    localparam logic [5:0] CMD_SELECT       = 6'd7;
    localparam logic [5:0] CMD_SEND_IF_COND = 6'd8;
    localparam logic [5:0] ACMD_SD_OP_COND  = 6'd41;
    localparam logic [5:0] CMD_APP          = 6'd55;

    // Command arguments and expected echo
    localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
    localparam logic [31:0] ARG_ACMD41 = 32'h40FF_8000;
    localparam logic [11:0] CMD8_ECHO  = 12'h1AA;

    typedef enum logic [3:0] {
        FC_NONE    = 4'd0,
        FC_TIMEOUT = 4'd1,
        FC_CRC     = 4'd2,
        FC_CMD8    = 4'd3,
        FC_CMD55   = 4'd4,
        FC_ACMD41  = 4'd5,
        FC_RCA     = 4'd6,
        FC_CMD7    = 4'd7
    } fail_code_e;

    // STEP_END marks "CMD7 accepted, finish after the trailing gap"
    typedef enum logic [2:0] {
        STEP_CMD0,
        STEP_CMD8,
        STEP_CMD55,
        STEP_ACMD41,
        STEP_CMD2,
        STEP_CMD3,
        STEP_CMD7,
        STEP_END
    } step_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_END,
        S_WAIT_RSP,
        S_GAP,
        S_DONE,
        S_FAIL
    } state_e;

    function automatic logic [5:0] step_cmd(step_e s);
        case (s)
            STEP_CMD8:   return CMD_SEND_IF_COND;
            STEP_CMD55:  return CMD_APP;
            STEP_ACMD41: return ACMD_SD_OP_COND;
            STEP_CMD2:   return CMD_ALL_SEND_CID;
            STEP_CMD3:   return CMD_SEND_RCA;
            STEP_CMD7:   return CMD_SELECT;
            default:     return CMD_GO_IDLE;
        endcase
    endfunction

    function automatic logic [31:0] step_arg(step_e s, logic [15:0] rca);
        case (s)
            STEP_CMD8:   return ARG_CMD8;
            STEP_ACMD41: return ARG_ACMD41;
            STEP_CMD7:   return {rca, 16'h0000};
            default:     return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/sd_init_ctrl_cyc_timer.sv
// Loadable down-counter; expire_o is high during the last counted cycle.
module sd_init_ctrl_cyc_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down and rest at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/sd_init_ctrl.sv
// SD card bring-up sequencer: CMD0, CMD8, CMD55/ACMD41 (retried), CMD2, CMD3,
// CMD7 over an external command transmitter and response receiver.
module sd_init_ctrl
    import sd_init_ctrl_pkg::*;
#(
    parameter int unsigned PWR_WAIT_CYC = 10000,
    parameter int unsigned GAP_CYC      = 1000,
    parameter int unsigned RSP_TIMEOUT  = 8192,
    parameter int unsigned ACMD41_MAX   = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        tx_en,
    output logic [5:0]  tx_cmd,
    output logic [31:0] tx_para,
    input  logic        tx_busy,
    output logic        rsp_long,
    input  logic        rsp_valid,
    input  logic [5:0]  rsp_cmd,
    input  logic [31:0] rsp_arg,
    input  logic        rsp_err,
    output logic        busy,
    output logic        init_done,
    output logic        init_fail,
    output logic [3:0]  fail_code,
    output logic [15:0] card_rca,
    output logic        card_ccs
);

    localparam logic [15:0] PWR_LOAD     = 16'(PWR_WAIT_CYC);
    localparam logic [15:0] GAP_LOAD     = 16'(GAP_CYC);
    localparam logic [15:0] RSP_LOAD     = 16'(RSP_TIMEOUT);
    localparam logic [9:0]  ACMD41_LIMIT = 10'(ACMD41_MAX);

    state_e     state_q, state_d;
    step_e      step_q, step_d;
    logic [9:0] retry_q, retry_d, retry_nxt;
    logic [15:0] rca_q, rca_d;
    logic       ccs_q, ccs_d;
    fail_code_e code_q, code_d;
    logic [5:0] cmd_q, cmd_d;
    logic [31:0] para_q, para_d;
    logic       long_q, long_d;
    logic       armed_q;

    logic       start_ok;
    logic       tmr_load;
    logic [15:0] tmr_val;
    logic       tmr_expire;
    logic       issue_load;
    logic       fail_set;
    fail_code_e fail_val;
    logic       unused_rsp;

    assign unused_rsp = ^rsp_arg[15:12];

    // A start coinciding with the first clock after reset release is dropped
    assign start_ok = start & armed_q;

    sd_init_ctrl_cyc_timer #(
        .W(16)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    // Next-state, step sequencing and response checking
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        retry_d    = retry_q;
        rca_d      = rca_q;
        ccs_d      = ccs_q;
        code_d     = code_q;
        cmd_d      = cmd_q;
        para_d     = para_q;
        long_d     = long_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        issue_load = 1'b0;
        fail_set   = 1'b0;
        fail_val   = FC_NONE;
        retry_nxt  = (retry_q == '1) ? retry_q : retry_q + 10'd1;

        unique case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_ok) begin
                    state_d  = S_PWR_WAIT;
                    step_d   = STEP_CMD0;
                    retry_d  = '0;
                    rca_d    = '0;
                    ccs_d    = 1'b0;
                    code_d   = FC_NONE;
                    tmr_load = 1'b1;
                    tmr_val  = PWR_LOAD;
                end
            end
            S_PWR_WAIT: begin
                if (tmr_expire) issue_load = 1'b1;
            end
            S_ISSUE: begin
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (tx_busy) state_d = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (!tx_busy) begin
                    tmr_load = 1'b1;
                    if (step_q == STEP_CMD0) begin
                        step_d  = STEP_CMD8;
                        state_d = S_GAP;
                        tmr_val = GAP_LOAD;
                    end else begin
                        state_d = S_WAIT_RSP;
                        tmr_val = RSP_LOAD;
                    end
                end
            end
            S_WAIT_RSP: begin
                if (rsp_valid) begin
                    state_d  = S_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    if (rsp_err) begin
                        fail_set = 1'b1;
                        fail_val = FC_CRC;
                    end else begin
                        case (step_q)
                            STEP_CMD8: begin
                                if (rsp_cmd == CMD_SEND_IF_COND && rsp_arg[11:0] == CMD8_ECHO)
                                    step_d = STEP_CMD55;
                                else begin
                                    fail_set = 1'b1;
                                    fail_val = FC_CMD8;
                                end
                            end
                            STEP_CMD55: begin
                                if (rsp_cmd == CMD_APP && rsp_arg[5])
                                    step_d = STEP_ACMD41;
                                else begin
                                    fail_set = 1'b1;
                                    fail_val = FC_CMD55;
                                end
                            end
                            STEP_ACMD41: begin
                                if (rsp_arg[31]) begin
                                    ccs_d  = rsp_arg[30];
                                    step_d = STEP_CMD2;
                                end else begin
                                    retry_d = retry_nxt;
                                    if (retry_nxt >= ACMD41_LIMIT) begin
                                        fail_set = 1'b1;
                                        fail_val = FC_ACMD41;
                                    end else begin
                                        step_d = STEP_CMD55;
                                    end
                                end
                            end
                            STEP_CMD2: begin
                                step_d = STEP_CMD3;
                            end
                            STEP_CMD3: begin
                                if (rsp_cmd == CMD_SEND_RCA && rsp_arg[31:16] != 16'h0000) begin
                                    rca_d  = rsp_arg[31:16];
                                    step_d = STEP_CMD7;
                                end else begin
                                    fail_set = 1'b1;
                                    fail_val = FC_RCA;
                                end
                            end
                            STEP_CMD7: begin
                                if (rsp_cmd == CMD_SELECT)
                                    step_d = STEP_END;
                                else begin
                                    fail_set = 1'b1;
                                    fail_val = FC_CMD7;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (tmr_expire) begin
                    fail_set = 1'b1;
                    fail_val = FC_TIMEOUT;
                end
            end
            S_GAP: begin
                if (tmr_expire) begin
                    if (step_q == STEP_END) state_d = S_DONE;
                    else                    issue_load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Command fields are registered on entry to ISSUE and held until the
        // next issue, so rsp_long stays valid while the response arrives
        if (issue_load) begin
            state_d = S_ISSUE;
            cmd_d   = step_cmd(step_q);
            para_d  = step_arg(step_q, rca_q);
            long_d  = (step_q == STEP_CMD2);
        end

        if (fail_set) begin
            state_d = S_FAIL;
            code_d  = fail_val;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= STEP_CMD0;
            retry_q <= '0;
            rca_q   <= '0;
            ccs_q   <= 1'b0;
            code_q  <= FC_NONE;
            cmd_q   <= '0;
            para_q  <= '0;
            long_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            retry_q <= retry_d;
            rca_q   <= rca_d;
            ccs_q   <= ccs_d;
            code_q  <= code_d;
            cmd_q   <= cmd_d;
            para_q  <= para_d;
            long_q  <= long_d;
            armed_q <= 1'b1;
        end
    end

    assign tx_en     = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK);
    assign busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL));
    assign init_done = (state_q == S_DONE);
    assign init_fail = (state_q == S_FAIL);
    assign fail_code = code_q;
    assign card_rca  = rca_q;
    assign card_ccs  = ccs_q;
    assign tx_cmd    = cmd_q;
    assign tx_para   = para_q;
    assign rsp_long  = long_q;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Testbench for sd_init_ctrl: transmitter/card model plus a command-sequence
// reference model derived from the initialisation rules.
module tb_sd_init_ctrl;

    localparam int unsigned P_PWR  = 20;
    localparam int unsigned P_GAP  = 8;
    localparam int unsigned P_TMO  = 100;
    localparam int unsigned P_AMAX = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tx_en;
    logic [5:0]  tx_cmd;
    logic [31:0] tx_para;
    logic        tx_busy = 1'b0;
    logic        rsp_long;
    logic        rsp_valid = 1'b0;
    logic [5:0]  rsp_cmd = '0;
    logic [31:0] rsp_arg = '0;
    logic        rsp_err = 1'b0;
    logic        busy;
    logic        init_done;
    logic        init_fail;
    logic [3:0]  fail_code;
    logic [15:0] card_rca;
    logic        card_ccs;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sd_init_ctrl #(
        .PWR_WAIT_CYC (P_PWR),
        .GAP_CYC      (P_GAP),
        .RSP_TIMEOUT  (P_TMO),
        .ACMD41_MAX   (P_AMAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tx_en     (tx_en),
        .tx_cmd    (tx_cmd),
        .tx_para   (tx_para),
        .tx_busy   (tx_busy),
        .rsp_long  (rsp_long),
        .rsp_valid (rsp_valid),
        .rsp_cmd   (rsp_cmd),
        .rsp_arg   (rsp_arg),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .init_done (init_done),
        .init_fail (init_fail),
        .fail_code (fail_code),
        .card_rca  (card_rca),
        .card_ccs  (card_ccs)
    );

    typedef struct packed {
        logic [5:0]  cmd;
        logic [31:0] para;
        logic        lng;
    } cmd_t;

    typedef enum int {K_OK, K_NORSP8, K_BAD8, K_BAD55, K_NEVER, K_CRC3, K_RCA0, K_BAD7, K_RST} kind_e;

    cmd_t obs_q[$];
    cmd_t exp_q[$];

    kind_e       sc_kind = K_OK;
    int unsigned sc_ready = 1, sc_ack = 0, sc_len = 2, sc_rdly = 1, sc_rst_at = 0;
    logic [15:0] sc_rca = 16'h1;
    logic        sc_ccs = 1'b0, sc_stray = 1'b0;
    int unsigned a41_cnt = 0, en_drop = 0, busy_fall_cyc = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [5:0] c, input logic [31:0] p, input logic l);
        cmd_t r;
        r.cmd = c; r.para = p; r.lng = l;
        return r;
    endfunction

    // Card side: answer each command according to the current scenario
    task automatic respond(input logic [5:0] c);
        logic        have;
        logic [5:0]  rc;
        logic [31:0] ra;
        logic        re;
        have = 1'b1; rc = c; ra = '0; re = 1'b0;
        case (c)
            6'd8:  begin
                if (sc_kind == K_NORSP8) have = 1'b0;
                ra = (sc_kind == K_BAD8) ? 32'h0000_01A5 : 32'h0000_01AA;
            end
            6'd55: ra = (sc_kind == K_BAD55) ? 32'h0000_0100 : 32'h0000_0120;
            6'd41: begin
                a41_cnt++;
                rc = 6'h3F;
                if (sc_kind == K_RST && a41_cnt == sc_rst_at) have = 1'b0;
                ra = {(sc_kind != K_NEVER && a41_cnt >= sc_ready), sc_ccs, 6'h00, 24'hFF8000};
            end
            6'd2:  begin rc = 6'h3F; ra = $urandom; end
            6'd3:  begin
                ra = {(sc_kind == K_RCA0) ? 16'h0000 : sc_rca, 16'h0500};
                re = (sc_kind == K_CRC3);
            end
            6'd7:  begin rc = (sc_kind == K_BAD7) ? 6'd6 : 6'd7; ra = 32'h0000_0900; end
            default: have = 1'b0;
        endcase
        if (!have) return;
        repeat (sc_rdly) @(negedge clk);
        rsp_valid = 1'b1; rsp_cmd = rc; rsp_arg = ra; rsp_err = re;
        @(negedge clk);
        rsp_valid = 1'b0; rsp_err = 1'b0;
        if (sc_stray) begin
            @(negedge clk);
            rsp_valid = 1'b1; rsp_err = 1'b1; rsp_cmd = 6'h3F; rsp_arg = $urandom;
            @(negedge clk);
            rsp_valid = 1'b0; rsp_err = 1'b0;
        end
    endtask

    // Transmitter side: acknowledge tx_en after sc_ack cycles, stay busy sc_len cycles
    initial begin : card_model
        cmd_t cur;
        forever begin
            @(negedge clk);
            if (rst_n && tx_en) begin
                cur = mk(tx_cmd, tx_para, rsp_long);
                for (int unsigned i = 0; i < sc_ack; i++) begin
                    @(negedge clk);
                    if (!tx_en) en_drop++;
                end
                obs_q.push_back(cur);
                tx_busy = 1'b1;
                repeat (sc_len) @(negedge clk);
                tx_busy = 1'b0;
                busy_fall_cyc = cyc;
                respond(cur.cmd);
            end
        end
    end

    // Reference: the command list a correct controller sends for this card
    task automatic predict(output logic e_done, output logic [3:0] e_code,
                           output logic [15:0] e_rca, output logic e_ccs);
        int unsigned attempts;
        exp_q.delete();
        e_done = 1'b0; e_code = 4'd0; e_rca = 16'h0; e_ccs = 1'b0;
        exp_q.push_back(mk(6'd0, 32'h0, 1'b0));
        exp_q.push_back(mk(6'd8, 32'h0000_01AA, 1'b0));
        if (sc_kind == K_NORSP8) begin e_code = 4'd1; return; end
        if (sc_kind == K_BAD8)   begin e_code = 4'd3; return; end
        attempts = (sc_kind == K_NEVER) ? P_AMAX : sc_ready;
        for (int unsigned a = 1; a <= attempts; a++) begin
            exp_q.push_back(mk(6'd55, 32'h0, 1'b0));
            if (sc_kind == K_BAD55) begin e_code = 4'd4; return; end
            exp_q.push_back(mk(6'd41, 32'h40FF_8000, 1'b0));
        end
        if (sc_kind == K_NEVER) begin e_code = 4'd5; return; end
        e_ccs = sc_ccs;
        exp_q.push_back(mk(6'd2, 32'h0, 1'b1));
        exp_q.push_back(mk(6'd3, 32'h0, 1'b0));
        if (sc_kind == K_CRC3) begin e_code = 4'd2; return; end
        if (sc_kind == K_RCA0) begin e_code = 4'd6; return; end
        e_rca = sc_rca;
        exp_q.push_back(mk(6'd7, {sc_rca, 16'h0000}, 1'b0));
        if (sc_kind == K_BAD7) begin e_code = 4'd7; return; end
        e_done = 1'b1;
    endtask

    task automatic set_scn(input kind_e k, input int unsigned rdy, input logic [15:0] rca,
                           input logic ccs, input int unsigned ack, input logic stray);
        sc_kind = k; sc_ready = rdy; sc_rca = rca; sc_ccs = ccs; sc_ack = ack; sc_stray = stray;
        sc_len  = 2 + $urandom_range(0, 5);
        sc_rdly = 1 + $urandom_range(0, 19);
    endtask

    task automatic run_scn(input string nm, input bit mid_start);
        logic        e_done, e_ccs;
        logic [3:0]  e_code;
        logic [15:0] e_rca;
        int unsigned t0, n, el;
        obs_q.delete(); a41_cnt = 0; en_drop = 0;
        predict(e_done, e_code, e_rca, e_ccs);
        t0 = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!tx_en && n < P_PWR + 10) begin @(negedge clk); n++; end
        el = cyc - t0;
        chk_eq({nm, "/pwr_wait"}, {63'd0, (el >= P_PWR && el <= P_PWR + 2)}, 64'd1);
        if (mid_start) begin
            repeat (30) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        n = 0;
        while (busy && n < 20000) begin @(negedge clk); n++; end
        chk_eq({nm, "/finished"}, {63'd0, busy}, 64'd0);
        if (sc_kind == K_NORSP8) begin
            el = cyc - busy_fall_cyc;
            chk_eq({nm, "/timeout_cycles"}, {63'd0, (el >= P_TMO && el <= P_TMO + 2)}, 64'd1);
        end
        repeat (3 * P_GAP + 20) @(negedge clk);
        chk_eq({nm, "/init_done"}, {63'd0, init_done}, {63'd0, e_done});
        chk_eq({nm, "/init_fail"}, {63'd0, init_fail}, {63'd0, !e_done});
        chk_eq({nm, "/fail_code"}, {60'd0, fail_code}, {60'd0, e_code});
        chk_eq({nm, "/card_rca"}, {48'd0, card_rca}, {48'd0, e_rca});
        chk_eq({nm, "/card_ccs"}, {63'd0, card_ccs}, {63'd0, e_ccs});
        chk_eq({nm, "/tx_en_idle"}, {63'd0, tx_en}, 64'd0);
        chk_eq({nm, "/en_held"}, 64'(en_drop), 64'd0);
        chk_eq({nm, "/n_cmds"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk_eq($sformatf("%s/cmd%0d", nm, i), 64'(obs_q[i]), 64'(exp_q[i]));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        kind_e k;
        int unsigned n;
        repeat (3) @(negedge clk);
        chk_eq("reset/outputs",
               {tx_en, busy, init_done, init_fail, fail_code, card_rca, card_ccs, rsp_long, tx_cmd, tx_para},
               64'd0);

        // start coinciding with reset release must be ignored
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk_eq("start_at_release", {63'd0, busy}, 64'd0);

        set_scn(K_OK, 3, 16'h1234, 1'b1, 1, 1'b0);
        run_scn("happy", 1'b1);
        chk_eq("happy/eleven_cmds", 64'(obs_q.size()), 64'd11);

        set_scn(K_NORSP8, 1, 16'h1111, 1'b0, 1, 1'b0);
        run_scn("no_rsp_cmd8", 1'b0);

        set_scn(K_BAD8, 1, 16'h2222, 1'b0, 0, 1'b0);
        run_scn("bad_cmd8", 1'b0);

        set_scn(K_NEVER, 1, 16'h3333, 1'b1, 1, 1'b0);
        run_scn("acmd41_never", 1'b0);
        chk_eq("acmd41_never/count", 64'(a41_cnt), 64'(P_AMAX));

        set_scn(K_CRC3, 2, 16'h4444, 1'b1, 2, 1'b0);
        run_scn("crc_cmd3", 1'b0);

        set_scn(K_OK, 2, 16'hBEEF, 1'b0, 50, 1'b1);
        run_scn("slow_ack_stray", 1'b0);

        set_scn(K_RCA0, 1, 16'h5555, 1'b1, 1, 1'b0);
        run_scn("rca_zero", 1'b0);
        set_scn(K_BAD55, 1, 16'h6666, 1'b0, 1, 1'b0);
        run_scn("bad_cmd55", 1'b0);
        set_scn(K_BAD7, 1, 16'h7777, 1'b1, 1, 1'b0);
        run_scn("bad_cmd7", 1'b0);

        // Reset while the second ACMD41 awaits its response
        set_scn(K_RST, 99, 16'h8888, 1'b1, 1, 1'b0);
        sc_rst_at = 2;
        obs_q.delete(); a41_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (a41_cnt < 2 && n < 5000) begin @(negedge clk); n++; end
        chk_eq("rst_mid/reached_acmd41", 64'(a41_cnt), 64'd2);
        repeat (5) @(negedge clk);
        chk_eq("rst_mid/busy_before", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_mid/outputs",
               {tx_en, busy, init_done, init_fail, fail_code, card_rca, card_ccs, rsp_long, tx_cmd, tx_para},
               64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        set_scn(K_OK, P_AMAX, 16'h0A0B, 1'b1, 1, 1'b0);
        run_scn("after_reset", 1'b0);

        for (int it = 0; it < 8; it++) begin
            k = kind_e'($urandom_range(0, 7));
            set_scn(k, $urandom_range(1, P_AMAX), 16'($urandom_range(1, 65535)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            run_scn($sformatf("rand%0d_k%0d", it, int'(k)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
